// File: rtl/hex_word_uart_tx.sv
// hex_word_uart_tx
//   Prints a captured data word to the console as uppercase ASCII hex,
//   most significant nibble first. It hands the characters one at a time to
//   uart_tx using that core's DV / Active / Done handshake.
//
//   Optional feature: define HEX_WORD_UART_TX_CRLF_EN to append CR (8'h0D)
//   and LF (8'h0A) after the hex characters. When it is defined, done_o
//   follows the tx_done_i of the LF.
//
// Ports
//   clk          system clock; everything is on the rising edge
//   rst          asynchronous active-high reset
//   word_i       word to print; sampled only when a request is accepted
//   valid_i      request; accepted when valid_i && ready_o
//   ready_o      high only while idle
//   done_o       one-cycle pulse after the last character's tx_done_i
//   tx_dv_o      to uart_tx i_Tx_DV; one-cycle pulse per character
//   tx_byte_o    to uart_tx i_Tx_Byte; held from the DV pulse until tx_done_i
//   tx_active_i  from uart_tx o_Tx_Active
//   tx_done_i    from uart_tx o_Tx_Done (one-cycle pulse)
module hex_word_uart_tx #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  tx_dv_o,
  output logic [7:0]            tx_byte_o,
  input  logic                  tx_active_i,
  input  logic                  tx_done_i
);

  localparam int HEX_CHARS = WORD_WIDTH / 4;
`ifdef HEX_WORD_UART_TX_CRLF_EN
  localparam int NCHARS = HEX_CHARS + 2;
`else
  localparam int NCHARS = HEX_CHARS;
`endif
  localparam int CW = $clog2(NCHARS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_DONE} state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] shift;
  logic [CW-1:0]         cnt;

  function automatic logic [7:0] ascii(input logic [3:0] d);
    // Digits map to '0'..'9'. 10..15 map to 'A'..'F' ('A' - 10 = 8'h37).
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready_o   <= 1'b1;
      done_o    <= 1'b0;
      tx_dv_o   <= 1'b0;
      tx_byte_o <= 8'h00;
      shift     <= '0;
      cnt       <= '0;
    end else begin
      done_o  <= 1'b0;
      tx_dv_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            shift   <= word_i;
            cnt     <= '0;
            ready_o <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
`ifdef HEX_WORD_UART_TX_CRLF_EN
          // Slots after the hex digits carry the line terminator.
          if (cnt < CW'(HEX_CHARS))
            tx_byte_o <= ascii(shift[WORD_WIDTH-1 -: 4]);
          else if (cnt == CW'(HEX_CHARS))
            tx_byte_o <= 8'h0D;
          else
            tx_byte_o <= 8'h0A;
`else
          tx_byte_o <= ascii(shift[WORD_WIDTH-1 -: 4]);
`endif
          state <= SEND;
        end
        SEND: begin
          // Wait for uart_tx to be completely idle. A done pulse still in
          // flight also counts as busy, so a stray pulse cannot be taken as
          // the completion of this character.
          if (!tx_active_i && !tx_done_i) begin
            tx_dv_o <= 1'b1;
            state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done_i) begin
            shift <= shift << 4;
            if (cnt == CW'(NCHARS - 1)) begin
              // The counter stops at the last slot, so it never wraps.
              done_o  <= 1'b1;
              ready_o <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt   <= cnt + CW'(1);
              state <= LOAD;
            end
          end
        end
        default: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
